// File: rtl/bcd_pkg.sv
// Shared 7-segment constants for the BCD display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;   // all segments off
    localparam logic [6:0] SEG_ERR   = 7'h3F;   // segment g only, marks a non-BCD code

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to common-anode 7-segment decoder with a blank override.
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // blank wins over decode; codes 10-15 show the error glyph
    always_comb begin
        seg = SEG_ERR;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// Multiplexed common-anode 7-segment driver for NUM_DIGITS BCD digits.
// A shadow register decouples the display from the counter chain; a
// prescaler sets how long each digit is held. seg/an are registered.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module bcd_disp_scan
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW    = $clog2(SCAN_DIV);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    adv_q, adv_d;
    logic                    scan_tick_q, scan_tick_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick;
    logic [3:0]              cur_bcd;
    logic                    blank;

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

    // prescaler, digit index and shadow capture; load and tick are independent
    always_comb begin
        presc_d  = tick ? '0 : presc_q + PW'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        shadow_d = load ? digits_in : shadow_q;
        // scan_tick lines up with the first cycle the new anode is driven,
        // which is one cycle after idx moves
        adv_d       = tick;
        scan_tick_d = adv_q;
    end

    // digit mux and anode select from the current index
    always_comb begin
        cur_bcd = shadow_q[3:0];
        an_d    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd = shadow_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
        end
    end

    // leading-zero blanking: digit i>0 blanks when it and every higher digit is 0
    always_comb begin
        blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        begin : lz
            logic lz_acc;
            lz_acc = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                lz_acc = lz_acc & (shadow_q[4*i +: 4] == 4'd0);
                if (idx_q == IDX_W'(i)) begin
                    blank = lz_acc;
                end
            end
        end
`endif
    end

    bcd_to_seg7 u_dec (
        .bcd   (cur_bcd),
        .blank (blank),
        .seg   (seg_d)
    );

    // state and output registers; clr blanks the display without a clock
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_q     <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            adv_q       <= 1'b0;
            scan_tick_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            adv_q       <= adv_d;
            scan_tick_q <= scan_tick_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Bench for bcd_disp_scan (NUM_DIGITS=4, SCAN_DIV=4). A cycle model derived
// from edge counts since reset release is compared every cycle, plus
// hand-computed literal checks at chosen points.
module tb_bcd_disp_scan;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk;
    logic          clr;
    logic [15:0]   din;
    logic          load;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          scan_tick;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_disp_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .clr       (clr),
        .digits_in (din),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [6:0] mdec(input logic [15:0] sh, input int i);
        logic [3:0] d;
        d = 4'((sh >> (4 * i)) & 16'hF);
`ifdef LEAD_ZERO_BLANK_EN
        if (i > 0 && (sh >> (4 * i)) == 16'h0) return 7'h7F;
`endif
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    int          m_n;       // edges since clr released
    logic [15:0] m_shadow;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_tick;

    // the digit shown after edge n+1 is digit (n / SD) % ND of the shadow held before it
    always @(posedge clk or negedge clr) begin
        int cur;
        if (!clr) begin
            m_n = 0; m_shadow = 16'h0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_tick = 1'b0;
        end else begin
            cur      = (m_n / SD) % ND;
            exp_an   = ~(4'b0001 << cur);
            exp_seg  = mdec(m_shadow, cur);
            exp_tick = (m_n > 0) && (m_n % SD == 0);
            if (load) m_shadow = din;
            m_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_seg",  32'(seg),       32'(exp_seg));
        chk("model_an",   32'(an),        32'(exp_an));
        chk("model_tick", 32'(scan_tick), 32'(exp_tick));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] t);
        int k;
        for (k = 0; k < 64; k++) begin
            step(1);
            if (an === t) break;
        end
        if (k == 64) chk("wait_an_timeout", 32'(an), 32'(t));
    endtask

    // async reset mid-cycle, checked before any clock edge; ends at a negedge still in reset
    task automatic do_reset();
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        chk("rst_seg",  32'(seg),       32'h7F);
        chk("rst_an",   32'(an),        32'hF);
        chk("rst_tick", 32'(scan_tick), 32'h0);
        @(negedge clk);
    endtask

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r = v; borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin r[4*i +: 4] = r[4*i +: 4] - 4'd1; borrow = 1'b0; end
            end
        end
        return r;
    endfunction

    logic lzb;
    logic [15:0] cnt;

    initial begin
`ifdef LEAD_ZERO_BLANK_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        clr = 1'b0; load = 1'b0; din = 16'h0;

        // 1. power-on reset then release
        repeat (2) @(negedge clk);
        chk("por_seg", 32'(seg), 32'h7F);
        chk("por_an",  32'(an),  32'hF);
        clr = 1'b1;
        step(1);
        chk("rel_an",  32'(an),  32'hE);
        chk("rel_seg", 32'(seg), 32'h40);

        // 2. scan of 1234, load on first edge after release
        step(5);
        do_reset();
        din = 16'h1234; load = 1'b1; clr = 1'b1;
        step(1);                               // edge 1
        load = 1'b0;
        chk("s_e1_seg", 32'(seg), 32'h40);
        step(1);                               // edge 2
        chk("s_e2_an",  32'(an),  32'hE);
        chk("s_e2_seg", 32'(seg), 32'h19);
        step(2);                               // edge 4
        chk("s_e4_an",   32'(an),        32'hE);
        chk("s_e4_tick", 32'(scan_tick), 32'h0);
        step(1);                               // edge 5
        chk("s_e5_an",   32'(an),        32'hD);
        chk("s_e5_seg",  32'(seg),       32'h30);
        chk("s_e5_tick", 32'(scan_tick), 32'h1);
        step(1);
        chk("s_e6_tick", 32'(scan_tick), 32'h0);
        step(3);                               // edge 9
        chk("s_e9_an",  32'(an),  32'hB);
        chk("s_e9_seg", 32'(seg), 32'h24);
        step(4);                               // edge 13
        chk("s_e13_an",  32'(an),  32'h7);
        chk("s_e13_seg", 32'(seg), 32'h79);
        step(4);                               // edge 17, wrapped
        chk("s_e17_an",   32'(an),        32'hE);
        chk("s_e17_seg",  32'(seg),       32'h19);
        chk("s_e17_tick", 32'(scan_tick), 32'h1);

        // 3. illegal digit and wrap
        din = 16'hA909; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_an(4'h7);
        chk("ill_seg", 32'(seg), 32'h3F);
        wait_an(4'hE);
        chk("wrap_seg", 32'(seg), 32'h10);

        // 4. load coincident with tick
        do_reset();
        clr = 1'b1;
        step(3);                               // edge 3
        din = 16'h9999; load = 1'b1;
        step(1);                               // edge 4 = tick edge
        load = 1'b0;
        chk("sim_e4_an",  32'(an),  32'hE);
        chk("sim_e4_seg", 32'(seg), 32'h40);
        step(1);
        chk("sim_e5_an",   32'(an),        32'hD);
        chk("sim_e5_seg",  32'(seg),       32'h10);
        chk("sim_e5_tick", 32'(scan_tick), 32'h1);

        // 5. leading zeros
        din = 16'h0050; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_an(4'h7); chk("lz_d3", 32'(seg), lzb ? 32'h7F : 32'h40);
        wait_an(4'hB); chk("lz_d2", 32'(seg), lzb ? 32'h7F : 32'h40);
        wait_an(4'hD); chk("lz_d1", 32'(seg), 32'h12);
        wait_an(4'hE); chk("lz_d0", 32'(seg), 32'h40);
        din = 16'h0000; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_an(4'hD); chk("z_d1", 32'(seg), lzb ? 32'h7F : 32'h40);
        wait_an(4'hE); chk("z_d0", 32'(seg), 32'h40);

        // 6. down-counting BCD chain loaded every cycle
        cnt = 16'h0000;
        for (int c = 0; c < 60; c++) begin
            din = cnt; load = 1'b1;
            step(1);
            chk("chain_no_illegal", 32'(seg == 7'h3F), 32'h0);
            cnt = bcd_dec(cnt);
        end
        load = 1'b0;
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
